// File: rtl/seq_multiplier.sv
// Sequential signed shift-add multiplier: one W+1-bit add/subtract per cycle,
// full 2W-bit two's-complement product after W cycles, start/busy/done handshake.
module seq_multiplier #(
   parameter int W = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic signed [W-1:0]    a,
   input  logic signed [W-1:0]    b,
   output logic                   busy,
   output logic                   done,
   output logic signed [2*W-1:0]  product
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             state;
   logic signed [W:0]  mcand;
   logic signed [W:0]  hi;
   logic signed [W:0]  sum;
   logic [W-1:0]       lo;
   logic [CW-1:0]      cnt;

   // The multiplier MSB carries negative weight, so the final partial product subtracts.
   function automatic logic signed [W:0] step_sum(input logic signed [W:0] acc,
                                                  input logic signed [W:0] m,
                                                  input logic              bit0,
                                                  input logic              last);
      if (!bit0)
         return acc;
      else if (last)
         return acc - m;
      else
         return acc + m;
   endfunction

   assign sum     = step_sum(hi, mcand, lo[0], cnt == LAST);
   assign product = {hi[W-1:0], lo};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         mcand <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  mcand <= {a[W-1], a};
                  hi    <= '0;
                  lo    <= b;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               // Arithmetic right shift of {sum, lo} by one bit.
               hi  <= {sum[W], sum[W:1]};
               lo  <= {sum[0], lo[W-1:1]};
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
